register_vectorial_mask: RTL
============================

# register_vectorial_mask

Parametrised vector register file for the vector datapath: NUM_REGS registers of LANES × LANE_W bits, NUM_RD combinational read ports and one write port. Beyond a plain register file it provides:
- per-lane write masking;
- write-to-read bypass;
- a pending-write scoreboard (busy bits);
- a sequenced bulk-clear engine.

It sits between decode/issue (reads, reservations) and writeback (writes). The default parameters give the existing 8 × 192-bit, 3-read-port configuration.

## Interface
Parameters:
- NUM_REGS, 8, number of vector registers (≥2, need not be a power of two)
- LANES, 8, lanes per register
- LANE_W, 24, bits per lane
- NUM_RD, 3, read ports
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W ≥ NUM_REGS

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- rs_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*LANES*LANE_W  read data, port i at bits [i*LANES*LANE_W +: LANES*LANE_W]
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write register
- wr_data  in  LANES*LANE_W  write data, lane k at bits [k*LANE_W +: LANE_W]
- wr_mask  in  LANES  lane enables; bit k enables lane k
- rsv_en  in  1  reserve register (mark pending write)
- rsv_addr  in  ADDR_W  register to reserve
- busy  out  NUM_REGS  scoreboard bit per register
- clr_req  in  1  start bulk clear
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when clear completes

## Operation
- Reset (rst=0): all registers 0, busy=0, FSM IDLE, clr_busy=0, clr_done=0. rd_data reflects zeroed array.
- Read: rd_data port i = register[rs_addr i]. Address ≥ NUM_REGS reads 0.
- Bypass: if a write is accepted this cycle and wr_addr == rs_addr i, each lane with wr_mask=1 returns the wr_data lane. Other lanes return the stored value.
- Write is accepted when wr_en=1, wr_addr < NUM_REGS and the FSM is IDLE. On acceptance, only the masked lanes update at the edge. All other writes are dropped silently.
- wr_mask=0 with an accepted write: no data change, but the busy bit still clears.
- Scoreboard:
  - rsv_en with rsv_addr < NUM_REGS sets busy[rsv_addr].
  - An accepted write clears busy[wr_addr].
  - Same address, same cycle: set wins, so busy stays 1.
  - Reservations are ignored while the FSM is not IDLE.
- Clear FSM:
  - IDLE: clr_req=1 → CLEAR, index=0, all busy bits cleared at the same edge.
  - CLEAR: zero register[index] each cycle, index+1. After index NUM_REGS-1 is zeroed → DONE.
  - DONE: clr_done=1 for one cycle → IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - clr_req is ignored outside IDLE.
- Bypass is inactive outside IDLE because no write is accepted. Reads during CLEAR return array contents, so registers are progressively zeroed.
- Reset asserted mid-clear: immediate return to IDLE with the full reset state.

## Timing
- Read latency 0 (combinational from rs_addr, stored array, and the bypass inputs wr_*).
- Write is visible in the array and on non-bypassed reads one cycle after the accepting edge.
- busy updates one cycle after rsv_en or the write.
- Clear timing: clr_req accepted at edge T → clr_busy=1 from T. Registers 0..NUM_REGS-1 are zeroed at edges T+1..T+NUM_REGS. clr_done=1 during cycle T+NUM_REGS. IDLE again from T+NUM_REGS+1.
- Total clear occupancy is NUM_REGS+1 cycles. A clr_req held high re-triggers on the first IDLE cycle.

## Structure
- Package vreg_pkg:
  - default parameter constants (NUM_REGS, LANES, LANE_W, NUM_RD, ADDR_W);
  - clear FSM state enum {IDLE, CLEAR, DONE};
  - lane-select helper function.
- Sub-module vreg_read_port, instantiated NUM_RD times via generate. It performs the address mux, the out-of-range zero and the per-lane bypass.
- Register array, scoreboard and FSM live in the top module.

## Test plan
- Reset then read all ports at addr 0, 5, 7 → all zeros; busy=8'h00; clr_busy=0.
- Write R3 = all lanes 24'hABCDEF with mask 8'hFF, then write R3 lanes 0..3 = 24'h000001 with mask 8'h0F. Read R3 → lanes 0..3 = 000001, lanes 4..7 = ABCDEF.
- Same-cycle write R2 = 24'h123456 (mask 8'h01) with rs_addr port 1 = 2 → lane 0 = 123456 combinationally, other lanes hold the old value. Address 9 reads 0; a write to address 9 changes nothing.
- rsv_en R4 → busy[4]=1 next cycle. Then rsv_en R4 and write R4 in the same cycle → busy[4] stays 1. Then a write R4 alone → busy[4]=0.
- Fill all registers with nonzero data, pulse clr_req → clr_busy for 9 cycles and clr_done pulses 8 cycles after acceptance. A write and a reservation issued during CLEAR are dropped, and all registers read 0 after done.
- Assert rst low at the 3rd CLEAR cycle → FSM IDLE, clr_busy=0, clr_done never pulses, all registers 0.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared definitions for the vector register file.
// Provides default geometry constants, the bulk-clear FSM state type and
// the per-lane select helper used by both the write path and read bypass.
package vreg_pkg;

    localparam int unsigned VREG_NUM_REGS = 8;
    localparam int unsigned VREG_LANES    = 8;
    localparam int unsigned VREG_LANE_W   = 24;
    localparam int unsigned VREG_NUM_RD   = 3;
    localparam int unsigned VREG_ADDR_W   = 4;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // A lane takes new write data only when the write targets it and its mask bit is set.
    function automatic logic lane_sel(input logic hit, input logic mask_bit);
        return hit & mask_bit;
    endfunction

endpackage

// File: rtl/vreg_read_port.sv
// One combinational read port of the vector register file.
// Ports:
//   regs_i     - full stored register array
//   rs_addr_i  - read address
//   wr_acc_i   - a write is being accepted this cycle
//   wr_addr_i  - write address (for bypass)
//   wr_data_i  - write data (for bypass)
//   wr_mask_i  - write lane enables (for bypass)
//   rd_data_o  - read data; zero for out-of-range addresses
module vreg_read_port
    import vreg_pkg::*;
#(
    parameter int unsigned NUM_REGS = VREG_NUM_REGS,
    parameter int unsigned LANES    = VREG_LANES,
    parameter int unsigned LANE_W   = VREG_LANE_W,
    parameter int unsigned ADDR_W   = VREG_ADDR_W
) (
    input  logic [NUM_REGS-1:0][LANES*LANE_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                     rs_addr_i,
    input  logic                                  wr_acc_i,
    input  logic [ADDR_W-1:0]                     wr_addr_i,
    input  logic [LANES*LANE_W-1:0]               wr_data_i,
    input  logic [LANES-1:0]                      wr_mask_i,
    output logic [LANES*LANE_W-1:0]               rd_data_o
);

    logic hit_c;

    // Address mux with implicit zero for unmapped addresses, then per-lane bypass.
    always_comb begin
        rd_data_o = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (32'(rs_addr_i) == r) begin
                rd_data_o = regs_i[r];
            end
        end
        // An accepted write always has an in-range address, so a hit implies a valid read.
        hit_c = wr_acc_i && (wr_addr_i == rs_addr_i);
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_sel(hit_c, wr_mask_i[k])) begin
                rd_data_o[k*LANE_W +: LANE_W] = wr_data_i[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/register_vectorial_mask.sv
// Vector register file with lane-masked writes, write-to-read bypass,
// a pending-write scoreboard and a sequenced bulk-clear engine.
// Ports:
//   clk, rst  - clock; asynchronous active-low reset
//   rs_addr   - NUM_RD packed read addresses
//   rd_data   - NUM_RD packed combinational read data
//   wr_en, wr_addr, wr_data, wr_mask - masked write port
//   rsv_en, rsv_addr - reserve a register (set its busy bit)
//   busy      - scoreboard, one bit per register
//   clr_req   - start bulk clear
//   clr_busy  - clear engine active (CLEAR or DONE)
//   clr_done  - one-cycle completion pulse
module register_vectorial_mask
    import vreg_pkg::*;
#(
    parameter int unsigned NUM_REGS = VREG_NUM_REGS,
    parameter int unsigned LANES    = VREG_LANES,
    parameter int unsigned LANE_W   = VREG_LANE_W,
    parameter int unsigned NUM_RD   = VREG_NUM_RD,
    parameter int unsigned ADDR_W   = VREG_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*ADDR_W-1:0]         rs_addr,
    output logic [NUM_RD*LANES*LANE_W-1:0]   rd_data,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [LANES*LANE_W-1:0]          wr_data,
    input  logic [LANES-1:0]                 wr_mask,
    input  logic                             rsv_en,
    input  logic [ADDR_W-1:0]                rsv_addr,
    output logic [NUM_REGS-1:0]              busy,
    input  logic                             clr_req,
    output logic                             clr_busy,
    output logic                             clr_done
);

    localparam int unsigned REG_W = LANES * LANE_W;

    clr_state_e                      state_q, state_d;
    logic [ADDR_W-1:0]               idx_q, idx_d;
    logic [NUM_REGS-1:0][REG_W-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            clr_busy_q, clr_busy_d;
    logic                            clr_done_q, clr_done_d;
    logic                            wr_acc_c;
    logic                            rsv_ok_c;

    // Writes are only honoured while the clear engine is idle.
    assign wr_acc_c = wr_en && (32'(wr_addr) < NUM_REGS) && (state_q == CLR_IDLE);
    assign rsv_ok_c = rsv_en && (32'(rsv_addr) < NUM_REGS);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLR_IDLE;
            idx_q      <= '0;
            regs_q     <= '0;
            busy_q     <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Next-state: array writes, scoreboard and clear sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        busy_d  = busy_q;

        unique case (state_q)
            CLR_IDLE: begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (wr_acc_c && (32'(wr_addr) == r)) begin
                        for (int unsigned k = 0; k < LANES; k++) begin
                            if (lane_sel(1'b1, wr_mask[k])) begin
                                regs_d[r][k*LANE_W +: LANE_W] = wr_data[k*LANE_W +: LANE_W];
                            end
                        end
                        busy_d[r] = 1'b0;
                    end
                end
                // Applied after the write so a same-register reservation wins.
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (rsv_ok_c && (32'(rsv_addr) == r)) begin
                        busy_d[r] = 1'b1;
                    end
                end
                // Starting a clear drops the whole scoreboard, including a same-cycle reservation.
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    idx_d   = '0;
                    busy_d  = '0;
                end
            end
            CLR_CLEAR: begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (32'(idx_q) == r) begin
                        regs_d[r] = '0;
                    end
                end
                idx_d = idx_q + ADDR_W'(1);
                if (32'(idx_q) == NUM_REGS - 1) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                state_d = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase

        clr_busy_d = (state_d != CLR_IDLE);
        clr_done_d = (state_d == CLR_DONE);
    end

    assign busy     = busy_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // Independent read ports sharing the stored array and bypass inputs.
    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        vreg_read_port #(
            .NUM_REGS (NUM_REGS),
            .LANES    (LANES),
            .LANE_W   (LANE_W),
            .ADDR_W   (ADDR_W)
        ) u_rd (
            .regs_i    (regs_q),
            .rs_addr_i (rs_addr[i*ADDR_W +: ADDR_W]),
            .wr_acc_i  (wr_acc_c),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .wr_mask_i (wr_mask),
            .rd_data_o (rd_data[i*REG_W +: REG_W])
        );
    end

endmodule
